// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants up to two of four result sources per cycle in
// round-robin order and drives two registered register-file write ports.
module wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      write1,
    output logic [4:0]                rd1,
    output logic [DATA_W-1:0]         write1_data,
    output logic                      write2,
    output logic [4:0]                rd2,
    output logic [DATA_W-1:0]         write2_data
);

    logic [1:0]        ptr;
    logic [4:0]        rd_a  [NUM_REQ];
    logic [DATA_W-1:0] dat_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign rd_a[i]  = req_rd[5*i +: 5];
        assign dat_a[i] = req_data[DATA_W*i +: DATA_W];
    end

    logic               g1;
    logic               g2;
    logic [1:0]         s1;
    logic [1:0]         s2;
    logic [1:0]         idx;
    logic [NUM_REQ-1:0] gnt;

    always_comb begin
        g1  = 1'b0;
        g2  = 1'b0;
        s1  = '0;
        s2  = '0;
        idx = '0;
        gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) begin
                // rd=0 results are dropped: always accepted, never use a port
                if (rd_a[idx] == 5'd0) begin
                    gnt[idx] = 1'b1;
                end else if (!g1) begin
                    g1       = 1'b1;
                    s1       = idx;
                    gnt[idx] = 1'b1;
                end else if (!g2 && rd_a[idx] != rd_a[s1]) begin
                    g2       = 1'b1;
                    s2       = idx;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = rst_n ? gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            write1      <= 1'b0;
            rd1         <= '0;
            write1_data <= '0;
            write2      <= 1'b0;
            rd2         <= '0;
            write2_data <= '0;
        end else begin
            if (g2) begin
                ptr <= s2 + 2'd1;
            end else if (g1) begin
                ptr <= s1 + 2'd1;
            end
            write1      <= g1;
            rd1         <= g1 ? rd_a[s1] : '0;
            write1_data <= g1 ? dat_a[s1] : '0;
            write2      <= g2;
            rd2         <= g2 ? rd_a[s2] : '0;
            write2_data <= g2 ? dat_a[s2] : '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based model of the grant rules.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         write1;
    logic [4:0]   rd1;
    logic [31:0]  write1_data;
    logic         write2;
    logic [4:0]   rd2;
    logic [31:0]  write2_data;

    wb_arbiter #(.DATA_W(32), .NUM_REQ(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_rd(req_rd),
        .req_data(req_data),
        .req_ready(req_ready),
        .write1(write1),
        .rd1(rd1),
        .write1_data(write1_data),
        .write2(write2),
        .rd2(rd2),
        .write2_data(write2_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    logic [3:0] last_rdy;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Rules: scan from mptr; rd=0 always ready; first nonzero-rd wins port 1,
    // next nonzero-rd with a different rd wins port 2; everyone else waits.
    task automatic model(input logic [3:0] v, input logic [19:0] rd,
                         output logic [3:0] rdy, output int s1, output int s2);
        int cand[$];
        int i;
        rdy = '0;
        s1  = -1;
        s2  = -1;
        for (int k = 0; k < 4; k++) begin
            i = (mptr + k) % 4;
            if (v[i]) begin
                if (rd[5*i +: 5] == 5'd0) rdy[i] = 1'b1;
                else cand.push_back(i);
            end
        end
        if (cand.size() > 0) begin
            s1 = cand[0];
            rdy[s1] = 1'b1;
            for (int j = 1; j < cand.size(); j++) begin
                if (s2 < 0 && rd[5*cand[j] +: 5] != rd[5*s1 +: 5])
                    s2 = cand[j];
            end
            if (s2 >= 0) rdy[s2] = 1'b1;
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [19:0] rd,
                         input logic [127:0] d, input logic rst);
        logic [3:0] rdy;
        int s1;
        int s2;
        @(negedge clk);
        req_valid = v;
        req_rd    = rd;
        req_data  = d;
        rst_n     = rst;
        #1;
        model(v, rd, rdy, s1, s2);
        if (!rst) rdy = '0;
        last_rdy = rdy;
        check("req_ready", req_ready, rdy);
        @(posedge clk);
        #1;
        if (!rst) begin
            s1 = -1;
            s2 = -1;
            mptr = 0;
        end else if (s2 >= 0) begin
            mptr = (s2 + 1) % 4;
        end else if (s1 >= 0) begin
            mptr = (s1 + 1) % 4;
        end
        check("write1", write1, s1 >= 0);
        check("rd1", rd1, s1 >= 0 ? rd[5*s1 +: 5] : 5'd0);
        check("data1", write1_data, s1 >= 0 ? d[32*s1 +: 32] : 32'd0);
        check("write2", write2, s2 >= 0);
        check("rd2", rd2, s2 >= 0 ? rd[5*s2 +: 5] : 5'd0);
        check("data2", write2_data, s2 >= 0 ? d[32*s2 +: 32] : 32'd0);
    endtask

    function automatic logic [19:0] pack_rd(input int a, input int b,
                                            input int c, input int e);
        return {5'(e), 5'(c), 5'(b), 5'(a)};
    endfunction

    logic [127:0] dd;
    logic [3:0]   rv;
    logic [19:0]  rr;
    logic [127:0] rdat;
    logic [3:0]   pend;

    initial begin
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        rst_n     = 1'b0;
        dd = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'hAAAA_0000};

        // reset held with everyone requesting, then idle
        cycle(4'b1111, pack_rd(1, 2, 3, 4), dd, 1'b0);
        cycle(4'b1111, pack_rd(1, 2, 3, 4), dd, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_w1", write1, 1'b0);
        cycle(4'b0000, '0, '0, 1'b1);
        check("idle_w1", write1, 1'b0);
        check("idle_w2", write2, 1'b0);

        // two grants from ptr=0
        cycle(4'b0101, pack_rd(5, 0, 7, 0), dd, 1'b1);
        check("two_rdy", last_rdy, 4'b0101);
        check("two_rd1", rd1, 5'd5);
        check("two_d1", write1_data, 32'hAAAA_0000);
        check("two_rd2", rd2, 5'd7);
        check("two_d2", write2_data, 32'h1234_5678);
        check("two_ptr", mptr, 3);

        // req3 alone brings ptr back to 0
        cycle(4'b1000, pack_rd(0, 0, 0, 1), dd, 1'b1);

        // same-rd conflict
        cycle(4'b0011, pack_rd(9, 9, 0, 0), dd, 1'b1);
        check("conf_w1", write1, 1'b1);
        check("conf_rd1", rd1, 5'd9);
        check("conf_d1", write1_data, 32'hAAAA_0000);
        check("conf_w2", write2, 1'b0);
        cycle(4'b0010, pack_rd(0, 9, 0, 0), dd, 1'b1);
        check("conf2_d1", write1_data, 32'h1111_1111);

        // rd=0 discard, ptr now 2
        cycle(4'b1010, pack_rd(0, 0, 0, 4), dd, 1'b1);
        check("rd0_rdy", last_rdy, 4'b1010);
        check("rd0_rd1", rd1, 5'd4);
        check("rd0_w2", write2, 1'b0);
        check("rd0_ptr", mptr, 0);

        // round-robin fairness
        for (int c = 0; c < 4; c++) begin
            cycle(4'b1111, pack_rd(11, 12, 13, 14), dd, 1'b1);
            check("rr_rd1", rd1, (c % 2 == 0) ? 5'd11 : 5'd13);
            check("rr_rd2", rd2, (c % 2 == 0) ? 5'd12 : 5'd14);
        end

        // reset mid-stream clears the pending write and ptr
        cycle(4'b1100, pack_rd(0, 0, 20, 21), dd, 1'b1);
        cycle(4'b0101, pack_rd(5, 0, 7, 0), dd, 1'b0);
        check("mid_w1", write1, 1'b0);
        check("mid_w2", write2, 1'b0);
        cycle(4'b1001, pack_rd(6, 0, 0, 8), dd, 1'b1);
        check("mid_rd1", rd1, 5'd6);

        // randomized traffic honouring the hold-until-granted rule
        pend = '0;
        rv = '0;
        rr = '0;
        rdat = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    rv[i] = ($urandom_range(0, 99) < 60);
                    rr[5*i +: 5] = 5'($urandom_range(0, 5));
                    rdat[32*i +: 32] = $urandom;
                end
            end
            cycle(rv, rr, rdat, $urandom_range(0, 39) != 0);
            pend = rv & ~last_rdy;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
